cond_issue_ctrl: RTL

//  Issue controller between decode and execute of the pipelined ARM-subset CPU.

---
 rtl/cond_issue_if.sv | 33 +++
 rtl/cond_issue_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/cond_issue_if.sv
// Decode/writeback-to-issue-controller bundle: instruction offer, flag writeback and issue status.
interface cond_issue_if #(
    parameter int PEND_W = 2
);
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [3:0]        cond_i;
    logic [1:0]        flag_write_i;
    logic              is_branch_i;
    logic              fw_valid_i;
    logic [1:0]        fw_mask_i;
    logic [3:0]        alu_flags_i;
    logic              exec_valid_o;
    logic              cond_ex_o;
    logic              flush_o;
    logic              illegal_o;
    logic [3:0]        flags_o;
    logic [PEND_W-1:0] pending_o;

    modport master (
        output instr_valid_i, cond_i, flag_write_i, is_branch_i,
               fw_valid_i, fw_mask_i, alu_flags_i,
        input  instr_ready_o, exec_valid_o, cond_ex_o, flush_o,
               illegal_o, flags_o, pending_o
    );

    modport slave (
        input  instr_valid_i, cond_i, flag_write_i, is_branch_i,
               fw_valid_i, fw_mask_i, alu_flags_i,
        output instr_ready_o, exec_valid_o, cond_ex_o, flush_o,
               illegal_o, flags_o, pending_o
    );
endinterface

// File: rtl/cond_issue_ctrl.sv
// Issue controller: owns NZCV, evaluates ARM condition codes, stalls on in-flight
// flag writes and opens a fixed flush window after a taken branch.
module cond_issue_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PEND_MAX     = 3,
    parameter int PEND_W       = 2
) (
    input logic         clk,
    input logic         reset,
    cond_issue_if.slave bus
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t            state;
    logic [CNT_W-1:0]  flush_cnt;
    logic [3:0]        flags_q;
    logic [PEND_W-1:0] pend_q;
    logic              exec_q, cond_ex_q, flush_q, illegal_q;

    logic [3:0]        byp;
    logic [PEND_W-1:0] pend_dec;
    logic              pass, pend_blocked, full_blocked, ready, accept, inc;

    // Condition evaluation sees this cycle's writeback so a flag producer and its
    // consumer can meet in the same cycle without an extra stall.
    always_comb begin
        byp = flags_q;
        if (bus.fw_valid_i && bus.fw_mask_i[1]) byp[3:2] = bus.alu_flags_i[3:2];
        if (bus.fw_valid_i && bus.fw_mask_i[0]) byp[1:0] = bus.alu_flags_i[1:0];

        pass = 1'b0;
        case (bus.cond_i)
            4'h0: pass = byp[2];
            4'h1: pass = !byp[2];
            4'h2: pass = byp[1];
            4'h3: pass = !byp[1];
            4'h4: pass = byp[3];
            4'h5: pass = !byp[3];
            4'h6: pass = byp[0];
            4'h7: pass = !byp[0];
            4'h8: pass = byp[1] && !byp[2];
            4'h9: pass = !byp[1] || byp[2];
            4'hA: pass = byp[3] == byp[0];
            4'hB: pass = byp[3] != byp[0];
            4'hC: pass = !byp[2] && (byp[3] == byp[0]);
            4'hD: pass = byp[2] || (byp[3] != byp[0]);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase

        pend_dec = pend_q;
        if (bus.fw_valid_i && (pend_q != '0)) pend_dec = pend_q - PEND_W'(1);

        pend_blocked = (bus.cond_i != 4'hE) && (pend_dec != '0);
        full_blocked = (bus.flag_write_i != '0) && (pend_dec == PEND_W'(PEND_MAX));
        ready        = (state != FLUSH) && !pend_blocked && !full_blocked;
        accept       = bus.instr_valid_i && ready;
        inc          = accept && (bus.flag_write_i != '0) && pass;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            flags_q   <= '0;
            pend_q    <= '0;
            exec_q    <= 1'b0;
            cond_ex_q <= 1'b0;
            flush_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            exec_q    <= accept;
            cond_ex_q <= accept && pass;
            illegal_q <= accept && (bus.cond_i == 4'hF);
            pend_q    <= pend_dec + PEND_W'(inc);
            if (bus.fw_valid_i) flags_q <= byp;

            case (state)
                RUN, STALL: begin
                    if (accept && bus.is_branch_i && pass) begin
                        state     <= FLUSH;
                        flush_q   <= 1'b1;
                        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                    end else if (bus.instr_valid_i && !ready) begin
                        state <= STALL;
                    end else begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= RUN;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready_o = ready;
    assign bus.exec_valid_o  = exec_q;
    assign bus.cond_ex_o     = cond_ex_q;
    assign bus.flush_o       = flush_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.flags_o       = flags_q;
    assign bus.pending_o     = pend_q;
endmodule
